pattern_monitor: RTL and testbench



---
 rtl/pattern_monitor_pkg.sv | 22 ++
 rtl/pattern_monitor_bcd_conv.sv | 84 ++++++++
 rtl/pattern_monitor.sv | 143 ++++++++++++++
 tb/tb_pattern_monitor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_monitor_pkg.sv
// Shared types and elaboration helpers for the pattern_monitor pipeline.
package pattern_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam logic [7:0] DEFAULT_TAPS_8 = 8'hB8;

    // True when BCD_DIGITS decimal digits can hold every CNT_W-bit value.
    function automatic bit bcd_digits_ok(input int cnt_w, input int digits);
        longint limit;
        limit = 1;
        for (int i = 0; i < digits; i++) begin
            limit = limit * 10;
        end
        return limit > ((longint'(1) << cnt_w) - 1);
    endfunction

endpackage

// File: rtl/pattern_monitor_bcd_conv.sv
// Sequential double-dabble converter: one input bit per cycle, result written on DONE.
module bcd_seq_conv
    import pattern_monitor_pkg::*;
#(
    parameter int CNT_W      = 10,
    parameter int BCD_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    abort,
    input  logic                    start,
    input  logic [CNT_W-1:0]        bin_in,
    output logic [4*BCD_DIGITS-1:0] bcd_out,
    output logic                    busy
);

    localparam int BW     = 4 * BCD_DIGITS;
    localparam int STEP_W = $clog2(CNT_W + 1);

    bcd_state_t        state;
    bcd_state_t        state_nxt;
    logic [CNT_W-1:0]  bin_r;
    logic [BW-1:0]     acc;
    logic [BW-1:0]     acc_adj;
    logic [STEP_W-1:0] steps;

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (steps == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r   <= '0;
            acc     <= '0;
            steps   <= '0;
            bcd_out <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_r <= bin_in;
                        acc   <= '0;
                        steps <= STEP_W'(CNT_W - 1);
                    end
                end
                SHIFT: begin
                    acc   <= {acc_adj[BW-2:0], bin_r[CNT_W-1]};
                    bin_r <= {bin_r[CNT_W-2:0], 1'b0};
                    if (steps != '0) begin
                        steps <= steps - STEP_W'(1);
                    end
                end
                DONE:    bcd_out <= acc;
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/pattern_monitor.sv
// LFSR stimulus, overlapping/non-overlapping pattern detector, detection counter,
// BCD readout and a reset-surviving shadow copy of the monitor state.
module pattern_monitor
    import pattern_monitor_pkg::*;
#(
    parameter int LFSR_W     = 8,
    parameter int PAT_W      = 4,
    parameter int CNT_W      = 10,
    parameter int BCD_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed,
    input  logic [LFSR_W-1:0]       taps,
    input  logic [PAT_W-1:0]        pattern,
    input  logic                    overlap,
    input  logic                    sat_mode,
    input  logic                    clr_count,
    input  logic                    save,
    input  logic                    restore,
    output logic                    lfsr_out,
    output logic                    detect,
    output logic [CNT_W-1:0]        count,
    output logic                    overflow,
    output logic [4*BCD_DIGITS-1:0] bcd_out,
    output logic                    bcd_valid
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    if (!bcd_digits_ok(CNT_W, BCD_DIGITS)) begin : g_bad_cfg
        $error("pattern_monitor: BCD_DIGITS too small for CNT_W");
    end

    logic [LFSR_W-1:0] lfsr;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [LFSR_W-1:0] sh_lfsr;
    logic [PAT_W-1:0]  sh_hist;
    logic [FILL_W-1:0] sh_fill;
    logic [CNT_W-1:0]  sh_count;
    logic              sh_overflow;

    logic              step;
    logic              fb;
    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    logic [CNT_W-1:0]  bcd_src;
    logic              bcd_busy;
    logic              bcd_start;

    assign lfsr_out = lfsr[LFSR_W-1];
    assign step     = en && !seed_load;
    assign fb       = ^(lfsr & taps);
    assign hist_nxt = {hist[PAT_W-2:0], lfsr_out};
    assign fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    assign match    = (hist_nxt == pattern) && (fill_inc == FILL_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= LFSR_W'(1);
            hist     <= '0;
            fill     <= '0;
            detect   <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (restore) begin
            lfsr     <= sh_lfsr;
            hist     <= sh_hist;
            fill     <= sh_fill;
            count    <= sh_count;
            overflow <= sh_overflow;
            detect   <= 1'b0;
        end else begin
            detect <= step && match;
            if (seed_load) begin
                lfsr <= (seed == '0) ? LFSR_W'(1) : seed;
                hist <= '0;
                fill <= '0;
            end else if (en) begin
                lfsr <= {lfsr[LFSR_W-2:0], fb};
                hist <= hist_nxt;
                fill <= (match && !overlap) ? '0 : fill_inc;
            end
            // A clear in the same cycle as a match drops that match from the count.
            if (clr_count) begin
                count    <= '0;
                overflow <= 1'b0;
            end else if (step && match) begin
                if (count == CNT_MAX) begin
                    count    <= sat_mode ? CNT_MAX : '0;
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    // No reset here so the snapshot survives power-gating resets.
    always_ff @(posedge clk) begin
        if (save && !restore) begin
            sh_lfsr     <= lfsr;
            sh_hist     <= hist;
            sh_fill     <= fill;
            sh_count    <= count;
            sh_overflow <= overflow;
        end
    end

    assign bcd_start = !bcd_busy && (count != bcd_src);

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_src <= '0;
        end else if (!restore && bcd_start) begin
            bcd_src <= count;
        end
    end

    bcd_seq_conv #(
        .CNT_W      (CNT_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .abort   (restore),
        .start   (bcd_start),
        .bin_in  (count),
        .bcd_out (bcd_out),
        .busy    (bcd_busy)
    );

    assign bcd_valid = !bcd_busy && (bcd_src == count);

endmodule

// File: tb/tb_pattern_monitor.sv
// Bench: two monitors (10-bit and 4-bit counters) on shared stimulus, checked
// against a queue-based behavioural model every cycle plus directed literal checks.
module tb_pattern_monitor;

    localparam int LW  = 4;
    localparam int PW  = 3;
    localparam int CW  = 10;
    localparam int BD  = 4;
    localparam int CWS = 4;
    localparam int BDS = 2;

    logic          clk = 1'b0;
    logic          rst, en, seed_load, overlap, sat_mode, clr_count, save, restore;
    logic [LW-1:0] seed, taps;
    logic [PW-1:0] pattern;

    logic            lfsr_out, detect, overflow, bcd_valid;
    logic [CW-1:0]   count;
    logic [4*BD-1:0] bcd_out;
    logic             s_lfsr_out, s_detect, s_overflow, s_bcd_valid;
    logic [CWS-1:0]   s_count;
    logic [4*BDS-1:0] s_bcd_out;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;
    int n_det, n_b2b;
    bit det_prev;

    // behavioural model state
    logic [LW-1:0] m_lfsr, sh_lfsr;
    bit            m_q[$];
    bit            sh_q[$];
    int            m_cnt, m_cnt_s, sh_cnt, sh_cnt_s;
    bit            m_ovf, m_ovf_s, sh_ovf, sh_ovf_s, m_det;

    bit seq[15] = '{0,0,0,1,0,0,1,1,0,1,0,1,1,1,1};

    pattern_monitor #(.LFSR_W(LW), .PAT_W(PW), .CNT_W(CW), .BCD_DIGITS(BD)) u_big (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed), .taps(taps),
        .pattern(pattern), .overlap(overlap), .sat_mode(sat_mode), .clr_count(clr_count),
        .save(save), .restore(restore), .lfsr_out(lfsr_out), .detect(detect), .count(count),
        .overflow(overflow), .bcd_out(bcd_out), .bcd_valid(bcd_valid));

    pattern_monitor #(.LFSR_W(LW), .PAT_W(PW), .CNT_W(CWS), .BCD_DIGITS(BDS)) u_small (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed), .taps(taps),
        .pattern(pattern), .overlap(overlap), .sat_mode(sat_mode), .clr_count(clr_count),
        .save(save), .restore(restore), .lfsr_out(s_lfsr_out), .detect(s_detect), .count(s_count),
        .overflow(s_overflow), .bcd_out(s_bcd_out), .bcd_valid(s_bcd_valid));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit window_matches();
        if (m_q.size() != PW) return 1'b0;
        for (int i = 0; i < PW; i++) begin
            if (m_q[i] != pattern[PW-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void bump(inout int c, inout bit o, input int w);
        if (c == (1 << w) - 1) begin
            if (!sat_mode) c = 0;
            o = 1'b1;
        end else begin
            c = c + 1;
        end
    endfunction

    always @(posedge clk) begin : model
        bit b, hit;
        hit = 1'b0;
        if (save && !restore) begin
            sh_lfsr = m_lfsr; sh_q = m_q;
            sh_cnt = m_cnt; sh_ovf = m_ovf; sh_cnt_s = m_cnt_s; sh_ovf_s = m_ovf_s;
        end
        if (rst) begin
            m_lfsr = 1; m_q.delete(); m_cnt = 0; m_ovf = 0; m_cnt_s = 0; m_ovf_s = 0; m_det = 0;
        end else if (restore) begin
            m_lfsr = sh_lfsr; m_q = sh_q;
            m_cnt = sh_cnt; m_ovf = sh_ovf; m_cnt_s = sh_cnt_s; m_ovf_s = sh_ovf_s; m_det = 0;
        end else begin
            if (seed_load) begin
                m_lfsr = (seed == 0) ? LW'(1) : seed;
                m_q.delete();
            end else if (en) begin
                b = m_lfsr[LW-1];
                m_lfsr = {m_lfsr[LW-2:0], ^(m_lfsr & taps)};
                m_q.push_back(b);
                if (m_q.size() > PW) void'(m_q.pop_front());
                hit = window_matches();
                if (hit && !overlap) m_q.delete();
            end
            m_det = hit;
            if (clr_count) begin
                m_cnt = 0; m_ovf = 0; m_cnt_s = 0; m_ovf_s = 0;
            end else if (hit) begin
                bump(m_cnt, m_ovf, CW);
                bump(m_cnt_s, m_ovf_s, CWS);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("lfsr_out", lfsr_out, m_lfsr[LW-1]);
            chk("detect", detect, m_det);
            chk("count", count, m_cnt);
            chk("overflow", overflow, m_ovf);
            chk("count_small", s_count, m_cnt_s);
            chk("overflow_small", s_overflow, m_ovf_s);
            if (bcd_valid) chk("bcd_out_vs_count", bcd_out, to_bcd(m_cnt));
            if (detect) n_det++;
            if (detect && det_prev) n_b2b++;
            det_prev = detect;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        en = 1'b1;
        while (m_cnt < target && guard < 20000) begin
            tick();
            guard++;
        end
        en = 1'b0;
        chk("run_to_count", count, target);
    endtask

    task automatic run_count(input bit ov, input bit sat);
        en = 0; overlap = ov; sat_mode = sat; seed = 4'b0001; seed_load = 1; clr_count = 1;
        tick();
        seed_load = 0; clr_count = 0; n_det = 0; n_b2b = 0; en = 1;
        repeat (150) tick();
        en = 0;
    endtask

    task automatic bcd_latency(input string name, input logic [15:0] exp);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk(name, bcd_valid, (k == 12));
        end
        chk({name, "_value"}, bcd_out, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int w, cur;
        rst = 1; en = 0; seed_load = 0; overlap = 1; sat_mode = 1; clr_count = 0;
        save = 0; restore = 0; seed = 4'b0001; taps = 4'b1100; pattern = 3'b111;
        tick(); tick();
        chk_on = 1;
        chk("rst_lfsr_out", lfsr_out, 0);
        chk("rst_count", count, 0);
        chk("rst_detect", detect, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_bcd_valid", bcd_valid, 1);
        chk("rst_bcd_out", bcd_out, 0);
        rst = 0;

        // LFSR period: two full periods of the output stream
        seed_load = 1; tick(); seed_load = 0; en = 1;
        for (int i = 0; i < 30; i++) begin
            chk("lfsr_seq", lfsr_out, seq[i % 15]);
            tick();
        end
        en = 0; seed = 0; seed_load = 1; tick(); seed_load = 0; en = 1;
        for (int i = 0; i < 8; i++) begin
            chk("lfsr_zero_seed", lfsr_out, seq[i]);
            tick();
        end
        en = 0; tick();
        chk("detect_en_low", detect, 0);

        run_count(1, 1);
        chk("ovl_count", count, 20);
        chk("ovl_ndet", n_det, 20);
        chk("sat_count", s_count, 15);
        chk("sat_overflow", s_overflow, 1);
        clr_count = 1; tick(); clr_count = 0;
        chk("clr_count", s_count, 0);
        chk("clr_overflow", s_overflow, 0);
        run_count(1, 0);
        chk("wrap_count", s_count, 4);
        chk("wrap_overflow", s_overflow, 1);
        run_count(0, 0);
        chk("noovl_count", count, 10);
        chk("noovl_ndet", n_det, 10);
        chk("noovl_b2b", n_b2b, 0);

        // BCD conversion and latency
        overlap = 1; clr_count = 1; tick(); clr_count = 0;
        run_to(998);
        repeat (20) tick();
        chk("bcd_998_valid", bcd_valid, 1);
        chk("bcd_998_value", bcd_out, 16'h0998);
        run_to(999);
        bcd_latency("bcd_999_lat", 16'h0999);
        run_to(1000);
        repeat (3) tick();
        clr_count = 1; tick(); clr_count = 0;
        w = 0;
        while (!bcd_valid && w < 40) begin
            tick();
            w++;
        end
        chk("bcd_reconv_lat", w, 20);
        chk("bcd_reconv_value", bcd_out, 0);

        // shadow save/restore across reset
        run_to(7);
        save = 1; tick(); save = 0;
        run_to(12);
        rst = 1; tick(); rst = 0;
        chk("shadow_rst_count", count, 0);
        restore = 1; tick(); restore = 0;
        chk("restore_count", count, 7);
        chk("restore_bcd_drop", bcd_valid, 0);
        bcd_latency("restore_bcd_lat", 16'h0007);
        en = 1; repeat (8) tick(); en = 0;
        run_to(9);
        save = 1; restore = 1; tick(); save = 0; restore = 0;
        chk("save_restore_count", count, 7);
        run_to(9);
        restore = 1; tick(); restore = 0;
        chk("shadow_kept_count", count, 7);

        // reset in the middle of a conversion
        cur = m_cnt;
        run_to(cur + 1);
        repeat (3) tick();
        rst = 1; tick(); rst = 0;
        chk("rst_shift_bcd_out", bcd_out, 0);
        chk("rst_shift_bcd_valid", bcd_valid, 1);
        chk("rst_shift_count", count, 0);
        chk("rst_shift_detect", detect, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
